// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: round-robin owner of a shared MUX_4/DEMUX_4 bus with select settle window.
// Optional hold-limit preemption is enabled by defining ARB_HOLD_LIMIT_EN.
module bus_arbiter_4 #(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_HOLD   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       bus_valid,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, OWN, RELEASE} state_t;
    state_t     state;
    logic [1:0] last;
    logic [1:0] pick;
    logic [3:0] cnt;
    logic       preempt;
    always_comb begin
        pick = last;
        for (int i = 3; i >= 0; i--)
            pick = req[2'(last + 2'(i + 1))] ? 2'(last + 2'(i + 1)) : pick;
    end
`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold;
    // hold counts completed OWN cycles, so the current cycle is number hold+1
    assign preempt = state == OWN && hold >= 8'(MAX_HOLD - 1) && |(req & ~gnt);
    always_ff @(posedge clk)
        hold <= (!rst_n || state != OWN) ? 8'd0 : (hold == 8'hff ? hold : hold + 8'd1);
`else
    assign preempt = MAX_HOLD < 0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            bus_valid <= 1'b0;
            busy      <= 1'b0;
            last      <= 2'd3;
            cnt       <= 4'd0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    gnt      <= 4'b1 << pick;
                    {s1, s0} <= pick;
                    last     <= pick;
                    cnt      <= 4'(SETTLE_CYC);
                    busy     <= 1'b1;
                    state    <= SETTLE;
                end
                SETTLE: if (!req[{s1, s0}]) begin
                    gnt   <= 4'b0;
                    state <= RELEASE;
                end else if (cnt == 4'd1) begin
                    bus_valid <= 1'b1;
                    state     <= OWN;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                OWN: if (!req[{s1, s0}] || preempt) begin
                    gnt       <= 4'b0;
                    bus_valid <= 1'b0;
                    state     <= RELEASE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_4.sv
// tb_bus_arbiter_4: directed scenarios plus random traffic against a grant-age reference model.
module tb_bus_arbiter_4;
    localparam int S = 2;
    localparam int H = 8;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [3:0] req = 0;
    logic [3:0] gnt;
    logic       s0, s1, bus_valid, busy;
    int checks = 0;
    int failures = 0;
    int m_idx = -1;
    int m_age = 0;
    int m_last = 3;
    int m_sel = 0;
    bit m_rel = 0;
    bit m_busy = 0;
    int order[$];

    always #5 clk = ~clk;

    bus_arbiter_4 #(.SETTLE_CYC(S), .MAX_HOLD(H)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .s0(s0), .s1(s1), .bus_valid(bus_valid), .busy(busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // model: an owner is described only by how many edges ago it was granted
    task automatic model_edge();
        int pick;
        bit drop, pre;
        if (!rst_n) begin
            m_idx = -1; m_age = 0; m_last = 3; m_sel = 0; m_rel = 0; m_busy = 0;
        end else if (m_rel) begin
            m_rel = 0; m_busy = 0;
        end else if (m_idx < 0) begin
            pick = -1;
            for (int k = 1; k <= 4; k++)
                if (pick < 0 && req[(m_last + k) % 4]) pick = (m_last + k) % 4;
            if (pick >= 0) begin
                m_idx = pick; m_sel = pick; m_last = pick; m_age = 0; m_busy = 1;
                order.push_back(pick);
            end
        end else begin
            drop = !req[m_idx];
            pre = 0;
`ifdef ARB_HOLD_LIMIT_EN
            pre = m_age >= S && (m_age - S + 1) >= H && (req & ~(4'b1 << m_idx)) != 0;
`endif
            if (drop || pre) begin
                m_idx = -1; m_rel = 1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic step();
        logic [3:0] eg;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        eg = (m_idx >= 0) ? 4'(4'b1 << m_idx) : 4'b0;
        check("gnt", 8'(gnt), 8'(eg));
        check("sel", 8'({s1, s0}), 8'(m_sel));
        check("bus_valid", 8'(bus_valid), 8'(m_idx >= 0 && m_age >= S));
        check("busy", 8'(busy), 8'(m_busy));
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
        order.delete();
    endtask

    initial begin
        int zrun;
        bit seen;
        // reset with all requests high, then first grant goes to 0
        rst_n = 0; req = 4'b1111;
        repeat (3) step();
        check("rst_gnt", 8'(gnt), 8'h00);
        check("rst_sel", 8'({s1, s0}), 8'h00);
        check("rst_valid", 8'(bus_valid), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        rst_n = 1;
        step();
        check("first_gnt", 8'(gnt), 8'h01);
        req = 0;
        repeat (4) step();
        // single requester latency
        req = 4'b0100;
        step();
        check("t2_gnt", 8'(gnt), 8'h04);
        check("t2_sel", 8'({s1, s0}), 8'h02);
        step();
        check("t2_early_valid", 8'(bus_valid), 8'h00);
        step();
        check("t2_valid", 8'(bus_valid), 8'h01);
        req = 0;
        step();
        check("t2_rel_gnt", 8'(gnt), 8'h00);
        check("t2_rel_busy", 8'(busy), 8'h01);
        step();
        check("t2_idle_busy", 8'(busy), 8'h00);
        // all request, each owner drops for one cycle after 3 OWN cycles
        do_reset();
        zrun = 0; seen = 0;
        repeat (60) begin
            req = (m_idx >= 0 && m_age == S + 2) ? (4'hf & ~(4'b1 << m_idx)) : 4'hf;
            step();
            if (gnt == 0) zrun++;
            else begin
                if (seen && zrun > 0) check("t3_gap", 8'(zrun), 8'd2);
                seen = 1; zrun = 0;
            end
        end
        check("t3_count", 8'(order.size() >= 5), 8'd1);
        for (int i = 0; i < 5 && i < order.size(); i++) check("t3_order", 8'(order[i]), 8'(i % 4));
        // requester drops during settle
        do_reset();
        req = 4'b0010;
        step();
        check("t4_gnt", 8'(gnt), 8'h02);
        req = 0;
        step();
        check("t4_rel_gnt", 8'(gnt), 8'h00);
        check("t4_rel_valid", 8'(bus_valid), 8'h00);
        step();
        check("t4_idle_busy", 8'(busy), 8'h00);
        // two requesters held continuously
        do_reset();
        req = 4'b0011;
        repeat (40) step();
`ifdef ARB_HOLD_LIMIT_EN
        check("t5_count", 8'(order.size() >= 3), 8'd1);
        for (int i = 0; i < 3 && i < order.size(); i++) check("t5_order", 8'(order[i]), 8'(i % 2));
`else
        check("t5_count", 8'(order.size()), 8'd1);
        check("t5_hold", 8'(gnt), 8'h01);
`endif
        // reset pulse during OWN restarts arbitration from requester 0
        do_reset();
        req = 4'b1111;
        repeat (4) step();
        check("t6_own", 8'(bus_valid), 8'h01);
        rst_n = 0;
        step();
        check("t6_gnt", 8'(gnt), 8'h00);
        check("t6_sel", 8'({s1, s0}), 8'h00);
        check("t6_valid", 8'(bus_valid), 8'h00);
        check("t6_busy", 8'(busy), 8'h00);
        rst_n = 1;
        step();
        check("t6_regrant", 8'(gnt), 8'h01);
        // random sticky traffic with occasional reset pulses
        repeat (3000) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            rst_n = $urandom_range(0, 299) != 0;
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
